// File: rtl/program_sequencer.sv
// program_sequencer: fetch-address generator for the Tron core.
// Handles sequential advance, conditional PC-relative branches, conditional
// absolute jumps, JAL through a register target, and call/return.
// Optional return-address stack: define PROGRAM_SEQUENCER_RAS_EN to build it.
// Without that macro, calls act as JAL to the immediate and returns jump to
// r_target. In that build the stack status outputs are tied off.
module program_sequencer #(
    parameter int unsigned      WIDTH      = 16,
    parameter int unsigned      RAS_DEPTH  = 8,
    parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_add,
    input  logic             pc_branch,
    input  logic             pc_jump,
    input  logic             pc_call,
    input  logic             pc_ret,
    input  logic [3:0]       cond,
    input  logic [15:0]      flags,
    input  logic [WIDTH-1:0] immediate,
    input  logic [WIDTH-1:0] r_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] link_out,
    output logic             link_valid,
    output logic             taken,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam logic [3:0] COND_JAL = 4'd15;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] link_q;
    logic             link_valid_q;
    logic             taken_q;

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] link_next;
    logic             link_set;
    logic             taken_next;
    logic             cond_ok;

    // flags[15:5] carry nothing the sequencer looks at
    logic             flags_unused;
    assign flags_unused = ^flags[15:5];

    assign pc_inc = pc_q + WIDTH'(1);

    // Evaluate the condition code against C/L/F/Z/N; code 15 (JAL) is never "true" here
    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            4'd0:    cond_ok = flags[3];
            4'd1:    cond_ok = !flags[3];
            4'd2:    cond_ok = flags[0];
            4'd3:    cond_ok = !flags[0];
            4'd4:    cond_ok = flags[1];
            4'd5:    cond_ok = !flags[1];
            4'd6:    cond_ok = flags[4];
            4'd7:    cond_ok = !flags[4];
            4'd8:    cond_ok = flags[2];
            4'd9:    cond_ok = !flags[2];
            4'd10:   cond_ok = !flags[1] && !flags[3];
            4'd11:   cond_ok = flags[1] || flags[3];
            4'd12:   cond_ok = !flags[3] && !flags[4];
            4'd13:   cond_ok = flags[3] || flags[4];
            4'd14:   cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

`ifdef PROGRAM_SEQUENCER_RAS_EN
    localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [CW-1:0]    count;
    logic             ras_err_q;
    logic [CW-2:0]    push_idx;
    logic [CW-2:0]    pop_idx;
    logic             push;
    logic             pop;
    logic             err_set;

    // count < RAS_DEPTH whenever a push happens, so its low bits index the slot
    assign push_idx  = count[CW-2:0];
    assign pop_idx   = push_idx - (CW-1)'(1);

    assign ras_empty = (count == '0);
    assign ras_full  = (count == CW'(RAS_DEPTH));
    assign ras_err   = ras_err_q;
`else
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 1'b0;
`endif

    // Select the next PC / link / taken by strobe priority: stall > ret > call > jump > branch > add
    always_comb begin
        pc_next    = pc_q;
        link_next  = link_q;
        link_set   = 1'b0;
        taken_next = 1'b0;
`ifdef PROGRAM_SEQUENCER_RAS_EN
        push       = 1'b0;
        pop        = 1'b0;
        err_set    = 1'b0;
`endif
        if (stall) begin
            pc_next = pc_q;
        end else if (pc_ret) begin
`ifdef PROGRAM_SEQUENCER_RAS_EN
            if (count != '0) begin
                pc_next    = stack[pop_idx];
                pop        = 1'b1;
                taken_next = 1'b1;
            end else begin
                pc_next = pc_inc;
                err_set = 1'b1;
            end
`else
            pc_next    = r_target;
            taken_next = 1'b1;
`endif
        end else if (pc_call) begin
            pc_next    = immediate;
            link_next  = pc_inc;
            link_set   = 1'b1;
            taken_next = 1'b1;
`ifdef PROGRAM_SEQUENCER_RAS_EN
            // a full stack drops the push but the call itself still happens
            if (count == CW'(RAS_DEPTH)) begin
                err_set = 1'b1;
            end else begin
                push = 1'b1;
            end
`endif
        end else if (pc_jump) begin
            if (cond == COND_JAL) begin
                pc_next    = r_target;
                link_next  = pc_inc;
                link_set   = 1'b1;
                taken_next = 1'b1;
            end else if (cond_ok) begin
                pc_next    = immediate;
                taken_next = 1'b1;
            end else begin
                pc_next = pc_inc;
            end
        end else if (pc_branch) begin
            if (cond_ok) begin
                pc_next    = pc_inc + immediate;
                taken_next = 1'b1;
            end else begin
                pc_next = pc_inc;
            end
        end else if (pc_add) begin
            pc_next = pc_inc;
        end
    end

    // PC, link and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_ADDR;
            link_q       <= '0;
            link_valid_q <= 1'b0;
            taken_q      <= 1'b0;
        end else begin
            pc_q         <= pc_next;
            link_q       <= link_next;
            link_valid_q <= link_set;
            taken_q      <= taken_next;
        end
    end

`ifdef PROGRAM_SEQUENCER_RAS_EN
    // Stack occupancy and sticky overflow/underflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            ras_err_q <= 1'b0;
        end else begin
            if (push) begin
                count <= count + CW'(1);
            end else if (pop) begin
                count <= count - CW'(1);
            end
            if (err_set) begin
                ras_err_q <= 1'b1;
            end
        end
    end

    // Stack storage; contents beyond count are don't-care so no reset is needed
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            stack[push_idx] <= pc_inc;
        end
    end
`endif

    assign pc_out     = pc_q;
    assign link_out   = link_q;
    assign link_valid = link_valid_q;
    assign taken      = taken_q;

endmodule
